// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl: execution controller for the MIPS pipeline under debug.
// Turns RUN/STEP/STOP/CLEAR debug commands into the pipeline enable and reset,
// detects halt retirement and keeps an executed-cycle counter.
// Optional PC breakpoint is compiled in when EXEC_CTRL_BREAKPOINT_EN is defined.
module mips_exec_ctrl #(
  parameter int unsigned NB_REG = 32,
  parameter int unsigned NB_CYC = 32
) (
  input  logic              i_du_clk,
  input  logic              i_du_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_mips_halt,
  input  logic [NB_REG-1:0] i_pc,
  input  logic              i_bp_wr,
  input  logic [NB_REG-1:0] i_bp_addr,
  output logic              o_mips_enable,
  output logic              o_mips_reset,
  output logic              o_done,
  output logic [1:0]        o_cause,
  output logic              o_busy,
  output logic [NB_CYC-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HALT = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;
  localparam logic [1:0] CAUSE_STOP = 2'b11;

  state_t     state, state_nxt;
  logic       cmd_acc;
  logic       bp_hit;
  logic       done_nxt;
  logic       rst_nxt;
  logic       cnt_clr;
  logic [1:0] cause_nxt;

  assign cmd_acc = i_cmd_valid & o_cmd_ready;

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [NB_REG-1:0] bp_addr_q;
  logic              bp_armed;
  logic              first_run;

  // Breakpoint register: loaded and armed by i_bp_wr, only reset disarms it.
  always_ff @(posedge i_du_clk or posedge i_du_reset) begin
    if (i_du_reset) begin
      bp_addr_q <= '0;
      bp_armed  <= 1'b0;
    end else if (i_bp_wr) begin
      bp_addr_q <= i_bp_addr;
      bp_armed  <= 1'b1;
    end
  end

  // Marks the first RUN cycle so a resume from the breakpoint PC can proceed.
  always_ff @(posedge i_du_clk or posedge i_du_reset) begin
    if (i_du_reset) first_run <= 1'b0;
    else            first_run <= (state != ST_RUN) && (state_nxt == ST_RUN);
  end

  assign bp_hit = bp_armed && (state == ST_RUN) && (i_pc == bp_addr_q) && !first_run;
`else
  logic bp_unused;
  assign bp_unused = ^{i_bp_wr, i_bp_addr, i_pc};
  assign bp_hit    = 1'b0;
`endif

  assign o_cmd_ready   = (state != ST_STEP);
  assign o_busy        = (state == ST_RUN) || (state == ST_STEP);
  assign o_mips_enable = ((state == ST_RUN) && !bp_hit) || (state == ST_STEP);

  // Next-state and registered-output decode; exit priority in RUN is halt > breakpoint > STOP.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    rst_nxt   = 1'b0;
    cnt_clr   = 1'b0;
    cause_nxt = o_cause;
    case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN: begin
              state_nxt = ST_RUN;
              cnt_clr   = 1'b1;
            end
            CMD_STEP: state_nxt = ST_STEP;
            CMD_CLEAR: begin
              rst_nxt   = 1'b1;
              cnt_clr   = 1'b1;
              cause_nxt = CAUSE_NONE;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (i_mips_halt) begin
          state_nxt = ST_HALTED;
          done_nxt  = 1'b1;
          cause_nxt = CAUSE_HALT;
        end else if (bp_hit || (cmd_acc && (i_cmd == CMD_STOP))) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          cause_nxt = CAUSE_STOP;
        end
      end
      ST_STEP: begin
        done_nxt = 1'b1;
        if (i_mips_halt) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_HALT;
        end else begin
          state_nxt = ST_IDLE;
          cause_nxt = CAUSE_STEP;
        end
      end
      ST_HALTED: begin
        if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
          state_nxt = ST_IDLE;
          rst_nxt   = 1'b1;
          cnt_clr   = 1'b1;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status pulses.
  always_ff @(posedge i_du_clk or posedge i_du_reset) begin
    if (i_du_reset) begin
      state        <= ST_IDLE;
      o_done       <= 1'b0;
      o_mips_reset <= 1'b0;
      o_cause      <= CAUSE_NONE;
    end else begin
      state        <= state_nxt;
      o_done       <= done_nxt;
      o_mips_reset <= rst_nxt;
      o_cause      <= cause_nxt;
    end
  end

  // Executed-cycle counter, saturating at all-ones.
  always_ff @(posedge i_du_clk or posedge i_du_reset) begin
    if (i_du_reset) begin
      o_cycle_count <= '0;
    end else if (cnt_clr) begin
      o_cycle_count <= '0;
    end else if (o_mips_enable && (o_cycle_count != '1)) begin
      o_cycle_count <= o_cycle_count + NB_CYC'(1);
    end
  end

endmodule

// File: doc/mips_exec_ctrl.md
# mips_exec_ctrl

Execution controller for the MIPS pipeline under debug. It takes RUN/STEP/STOP/CLEAR commands from the debug unit and generates the pipeline's global enable and reset. It detects halt retirement and an optional PC breakpoint, and keeps an executed-cycle counter for the dump. It sits between the debug unit's command FSM and the pipeline's stall/enable and reset inputs.

## Interface
- NB_REG, 32, width of PC and breakpoint address
- NB_CYC, 32, width of cycle counter
- i_du_clk  in  1  clock
- i_du_reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command strobe
- i_cmd  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP
- o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready
- i_mips_halt  in  1  halt instruction (0xFC000000) retired in WB this cycle
- i_pc  in  NB_REG  current fetch PC
- i_bp_wr  in  1  load breakpoint register (macro only)
- i_bp_addr  in  NB_REG  breakpoint address (macro only)
- o_mips_enable  out  1  pipeline advance enable
- o_mips_reset  out  1  one-cycle pipeline reset pulse
- o_done  out  1  one-cycle pulse when execution stops
- o_cause  out  2  00 none, 01 halt, 10 step, 11 stop/breakpoint
- o_busy  out  1  state is RUN or STEP
- o_cycle_count  out  NB_CYC  enabled cycles since last CLEAR/RUN-from-IDLE

## Operation
- States: IDLE, RUN, STEP, HALTED.
- IDLE:
  - RUN → RUN; clears o_cycle_count.
  - STEP → STEP; count not cleared.
  - CLEAR → stays IDLE; pulses o_mips_reset; clears count and o_cause.
  - STOP is ignored.
- RUN: o_mips_enable=1. Exit priority per cycle is halt > breakpoint > STOP:
  - i_mips_halt → HALTED, cause 01.
  - Breakpoint hit → IDLE, cause 11.
  - STOP accepted → IDLE, cause 11.
  - RUN/STEP/CLEAR are accepted and ignored.
- STEP:
  - Enable is high for exactly one cycle, then the state leaves STEP.
  - Destination is HALTED (cause 01) if i_mips_halt is high during that cycle, else IDLE (cause 10).
  - o_cmd_ready=0.
- HALTED:
  - Only CLEAR has effect: → IDLE, reset pulse, count cleared.
  - RUN/STEP/STOP are accepted and ignored.
- o_cmd_ready=1 in IDLE, RUN, HALTED; 0 in STEP.
- o_cause holds its value until the next exit event or CLEAR.
- o_cycle_count increments on every edge where o_mips_enable=1 and saturates at all-ones.

## Timing
- Reset values: state IDLE; o_mips_enable 0, o_mips_reset 0, o_done 0, o_cause 00, o_busy 0, o_cycle_count 0, breakpoint disarmed. Reset mid-RUN drops enable asynchronously.
- o_mips_enable and o_busy are combinational from state; enable is additionally gated by the breakpoint hit.
- The command accepted at edge N changes state at N; enable is high in the cycle after N.
- o_done, o_cause and o_mips_reset are registered. They are valid in the cycle after the terminating edge; o_done and o_mips_reset are high for exactly 1 cycle.
- Halt and STOP in the same cycle: halt wins, cause 01.
- The cycle in which i_mips_halt is sampled is counted, since enable was high.

## Configuration
- EXEC_CTRL_BREAKPOINT_EN defined: breakpoint logic is compiled in.
  - i_bp_wr loads the address and arms it; CLEAR does not disarm.
  - Hit = armed & state RUN & i_pc==bp & not first RUN cycle. The first-cycle exclusion lets resume from a breakpoint proceed.
  - On a hit, o_mips_enable is forced 0 that same cycle, so the instruction at the breakpoint address is not fetched/advanced.
- EXEC_CTRL_BREAKPOINT_EN undefined: i_bp_wr/i_bp_addr are unused, hit is constant 0, and no breakpoint register exists.

## Test plan
- Run to halt: reset; RUN; i_mips_halt at the 10th enabled cycle → state HALTED, o_done pulse, o_cause=01, o_cycle_count=10, enable 0; a following RUN has no effect.
- Step: from IDLE, three STEP commands spaced 3 cycles apart → enable high in exactly 3 cycles total, three o_done pulses, cause=10, count=3; o_cmd_ready=0 during each step cycle.
- STOP versus halt in the same cycle while RUN → cause=01, state HALTED; STOP alone after 5 cycles → IDLE, cause=11, count=5.
- CLEAR from HALTED → one-cycle o_mips_reset, count 0, cause 00, IDLE; then RUN restarts the count from 0.
- Breakpoint (macro on): bp=0x10, RUN with PC stepping by 4 from 0 → enable low in the cycle where PC=0x10, IDLE with cause 11, count=4. A second RUN passes 0x10 and continues to halt.
- Async reset asserted mid-RUN → enable drops before the next edge, all outputs at reset values, breakpoint disarmed.
